// File: rtl/traffic_light_conflict_monitor.sv
// Lamp-side safety monitor: filters static lamp faults and per-head aspect
// sequences, and latches a coded fault until a clean all-red clear request.
module traffic_light_conflict_monitor #(
  parameter int FILTER_CYCLES     = 4,
  parameter int YELLOW_MIN_CYCLES = 30_000_000,
  parameter int CNT_BITS          = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] primaryRoadLight_RYG,
  input  logic [2:0] secondaryRoadLight_RYG,
  input  logic       faultClear,
  output logic       fault,
  output logic [2:0] faultCode,
  output logic [7:0] faultCount
);

  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam logic [FW-1:0] F_MAX  = FW'(FILTER_CYCLES);
  localparam logic [FW-1:0] F_LAST = FW'(FILTER_CYCLES - 1);
  localparam logic [FW-1:0] F_ONE  = FW'(1);
  localparam logic [CNT_BITS-1:0] Y_MIN = CNT_BITS'(YELLOW_MIN_CYCLES);

  localparam logic [2:0] L_R = 3'b100;
  localparam logic [2:0] L_Y = 3'b010;
  localparam logic [2:0] L_G = 3'b001;

  localparam logic [2:0] C_NONE     = 3'd0;
  localparam logic [2:0] C_CONFLICT = 3'd1;
  localparam logic [2:0] C_MULTI    = 3'd2;
  localparam logic [2:0] C_DARK     = 3'd3;
  localparam logic [2:0] C_SKIP     = 3'd4;
  localparam logic [2:0] C_SHORT    = 3'd5;

  typedef enum logic {
    S_ARMED,
    S_FAULT
  } state_t;

  state_t r_state;
  logic       r_fault;
  logic [2:0] r_code;
  logic [7:0] r_count;

  logic [2:0]          w_raw   [2];
  logic [2:0]          r_acc   [2];
  logic [2:0]          r_cand  [2];
  logic [FW-1:0]       r_acnt  [2];
  logic [FW-1:0]       w_run   [2];
  logic [CNT_BITS-1:0] r_ycnt  [2];
  logic [1:0]          w_onehot;
  logic [1:0]          w_change;
  logic [1:0]          w_accept;
  logic [1:0]          w_skip;
  logic [1:0]          w_short;

  // Static checks: [0]=CONFLICT [1]=MULTI_LAMP [2]=DARK
  logic [2:0]    w_cond;
  logic [2:0]    w_sfire;
  logic [FW-1:0] r_scnt [3];

  logic       w_any;
  logic [2:0] w_code;
  logic       w_clear_ok;

  assign w_raw[0] = primaryRoadLight_RYG;
  assign w_raw[1] = secondaryRoadLight_RYG;

  function automatic logic multi_lit(input logic [2:0] l);
    return (l[2] & l[1]) | (l[2] & l[0]) | (l[1] & l[0]);
  endfunction

  always_comb begin
    w_cond[0] = (|primaryRoadLight_RYG[1:0]) &
                (|secondaryRoadLight_RYG[1:0]);
    w_cond[1] = multi_lit(primaryRoadLight_RYG) |
                multi_lit(secondaryRoadLight_RYG);
    w_cond[2] = (primaryRoadLight_RYG == 3'b000) |
                (secondaryRoadLight_RYG == 3'b000);
    for (int i = 0; i < 3; i++) begin
      w_sfire[i] = w_cond[i] && (r_scnt[i] == F_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        r_scnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!w_cond[i]) begin
          r_scnt[i] <= '0;
        end else if (r_scnt[i] != F_MAX) begin
          r_scnt[i] <= r_scnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int h = 0; h < 2; h++) begin
      w_onehot[h] = (w_raw[h] == L_R) ||
                    (w_raw[h] == L_Y) ||
                    (w_raw[h] == L_G);
      w_change[h] = w_onehot[h] && (w_raw[h] != r_acc[h]);
      w_run[h]    = ((r_acnt[h] != '0) && (w_raw[h] == r_cand[h])) ?
                    r_acnt[h] + 1'b1 : F_ONE;
      w_accept[h] = w_change[h] && (w_run[h] == F_MAX);
      w_skip[h]   = w_accept[h] && (r_acc[h] == L_G) &&
                    (w_raw[h] == L_R);
      w_short[h]  = w_accept[h] && (r_acc[h] == L_Y) &&
                    (w_raw[h] == L_R) && (r_ycnt[h] < Y_MIN);
    end
  end

  // Dwell counts from acceptance to acceptance, so filter delay cancels.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int h = 0; h < 2; h++) begin
        r_acc[h]  <= L_R;
        r_cand[h] <= L_R;
        r_acnt[h] <= '0;
        r_ycnt[h] <= '0;
      end
    end else begin
      for (int h = 0; h < 2; h++) begin
        if (w_accept[h]) begin
          r_acc[h]  <= w_raw[h];
          r_acnt[h] <= '0;
        end else if (w_change[h]) begin
          r_cand[h] <= w_raw[h];
          r_acnt[h] <= w_run[h];
        end else begin
          r_acnt[h] <= '0;
        end
        if (w_accept[h] && (w_raw[h] == L_Y)) begin
          r_ycnt[h] <= '0;
        end else if ((r_acc[h] == L_Y) && (r_ycnt[h] != '1)) begin
          r_ycnt[h] <= r_ycnt[h] + 1'b1;
        end
      end
    end
  end

  assign w_any = (|w_sfire) | (|w_skip) | (|w_short);

  always_comb begin
    w_code = C_NONE;
    priority case (1'b1)
      w_sfire[0]: w_code = C_CONFLICT;
      w_sfire[1]: w_code = C_MULTI;
      w_sfire[2]: w_code = C_DARK;
      |w_skip:    w_code = C_SKIP;
      |w_short:   w_code = C_SHORT;
      default:    w_code = C_NONE;
    endcase
  end

  assign w_clear_ok = faultClear &&
                      (primaryRoadLight_RYG == L_R) &&
                      (secondaryRoadLight_RYG == L_R) &&
                      !w_any;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_ARMED;
      r_fault <= 1'b0;
      r_code  <= C_NONE;
      r_count <= '0;
    end else begin
      unique case (r_state)
        S_ARMED: begin
          if (w_any) begin
            r_state <= S_FAULT;
            r_fault <= 1'b1;
            r_code  <= w_code;
            if (r_count != 8'hFF) begin
              r_count <= r_count + 1'b1;
            end
          end
        end
        S_FAULT: begin
          if (w_clear_ok) begin
            r_state <= S_ARMED;
            r_fault <= 1'b0;
            r_code  <= C_NONE;
          end
        end
        default: r_state <= S_ARMED;
      endcase
    end
  end

  assign fault      = r_fault;
  assign faultCode  = r_code;
  assign faultCount = r_count;

endmodule

// File: tb/tb_traffic_light_conflict_monitor.sv
// Directed bench for the lamp conflict monitor with a scoreboard of
// expected {fault, faultCode, faultCount} at each checkpoint.
module tb_traffic_light_conflict_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] D = 3'b000;
  localparam logic [2:0] M = 3'b110;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] pr;
  logic [2:0] se;
  logic       fc;
  logic       fault;
  logic [2:0] faultCode;
  logic [7:0] faultCount;

  typedef struct {
    string       tag;
    logic [11:0] v;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  traffic_light_conflict_monitor #(
    .FILTER_CYCLES(2),
    .YELLOW_MIN_CYCLES(10),
    .CNT_BITS(25)
  ) dut (
    .clk(clk),
    .reset(reset),
    .primaryRoadLight_RYG(pr),
    .secondaryRoadLight_RYG(se),
    .faultClear(fc),
    .fault(fault),
    .faultCode(faultCode),
    .faultCount(faultCount)
  );

  always #50 clk = ~clk;

  task automatic drive(input logic [2:0] p, input logic [2:0] s,
                       input logic clr, input int n);
    for (int i = 0; i < n; i++) begin
      pr = p;
      se = s;
      fc = clr;
      @(posedge clk);
      #1;
    end
    fc = 1'b0;
  endtask

  task automatic chk(input string tag, input logic f,
                     input logic [2:0] c, input logic [7:0] n);
    exp_t e;
    logic [11:0] obs;
    e.tag = tag;
    e.v   = {f, c, n};
    sb.push_back(e);
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = {fault, faultCode, faultCount};
      checks++;
      assert (obs === e.v) else begin
        errors++;
        $error("FAIL %s: observed f=%b c=%0d n=%0d expected f=%b c=%0d n=%0d",
               e.tag, obs[11], obs[10:8], obs[7:0],
               e.v[11], e.v[10:8], e.v[7:0]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    pr = R;
    se = R;
    fc = 1'b0;
    drive(R, R, 0, 2);
    chk("reset", 0, 0, 0);
    reset = 1'b0;

    drive(R, R, 0, 3);
    drive(G, R, 0, 20);
    chk("seq_GR", 0, 0, 0);
    drive(Y, R, 0, 12);
    drive(R, R, 0, 5);
    chk("seq_YR_RR", 0, 0, 0);
    drive(R, G, 0, 20);
    drive(R, Y, 0, 12);
    drive(R, R, 0, 5);
    chk("seq_full", 0, 0, 0);

    drive(R, G, 0, 20);
    drive(G, G, 0, 1);
    drive(R, G, 0, 3);
    chk("conflict_glitch", 0, 0, 0);
    drive(G, G, 0, 1);
    chk("conflict_1st", 0, 0, 0);
    drive(G, G, 0, 1);
    chk("conflict_2nd", 1, 1, 1);
    drive(R, R, 0, 4);
    chk("fault_hold", 1, 1, 1);
    drive(R, R, 1, 1);
    chk("clear1", 0, 0, 1);

    drive(G, R, 0, 20);
    chk("green_armed", 0, 0, 1);
    drive(R, R, 0, 1);
    chk("skip_1st", 0, 0, 1);
    drive(R, R, 0, 1);
    chk("skip_2nd", 1, 4, 2);
    drive(R, D, 0, 3);
    chk("dark_in_fault", 1, 4, 2);
    drive(G, R, 1, 1);
    chk("clear_nonred", 1, 4, 2);
    drive(R, R, 0, 2);
    drive(G, R, 0, 2);
    drive(R, R, 0, 1);
    drive(R, R, 1, 1);
    chk("clear_vs_fire", 1, 4, 2);
    drive(R, R, 1, 1);
    chk("clear2", 0, 0, 2);

    drive(Y, R, 0, 5);
    drive(R, R, 0, 1);
    chk("short_1st", 0, 0, 2);
    drive(R, R, 0, 1);
    chk("short_yellow", 1, 5, 3);
    drive(R, R, 1, 1);
    chk("clear3", 0, 0, 3);
    drive(Y, R, 0, 11);
    drive(R, R, 0, 2);
    chk("yellow_at_min", 0, 0, 3);

    drive(R, M, 0, 1);
    chk("multi_1st", 0, 0, 3);
    drive(R, M, 0, 1);
    chk("multi", 1, 2, 4);
    drive(R, R, 1, 1);
    chk("clear4", 0, 0, 4);
    drive(D, M, 0, 2);
    chk("multi_over_dark", 1, 2, 5);
    drive(R, R, 1, 1);
    chk("clear5", 0, 0, 5);

    drive(G, M, 0, 1);
    chk("conf_multi_1st", 0, 0, 5);
    drive(G, M, 0, 1);
    chk("conf_over_multi", 1, 1, 6);
    reset = 1'b1;
    drive(G, G, 1, 1);
    chk("reset_mid_fault", 0, 0, 0);
    reset = 1'b0;
    drive(R, R, 0, 2);
    chk("after_reset", 0, 0, 0);
    drive(Y, R, 0, 4);
    reset = 1'b1;
    drive(R, R, 0, 1);
    reset = 1'b0;
    drive(R, R, 0, 3);
    chk("reset_mid_yellow", 0, 0, 0);

    for (int k = 1; k <= 256; k++) begin
      drive(R, D, 0, 2);
      if (k == 1 || k == 255 || k == 256) begin
        chk($sformatf("dark_evt%0d", k), 1, 3,
            (k > 255) ? 8'd255 : 8'(k));
      end
      drive(R, R, 1, 1);
    end
    chk("count_sat", 0, 0, 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
